// File: rtl/load_store_unit.sv
// Memory-access stage: decodes RV32 load/store funct3, drives a ready-handshake
// data-memory request and returns sign/zero-extended load data for writeback.
module load_store_unit #(
  parameter int unsigned width    = 32,
  parameter int unsigned d        = 128,
  parameter int unsigned max_wait = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [width-1:0]     addr,
  input  logic [width-1:0]     wdata,
  output logic                 stall,
  output logic                 done,
  output logic                 fault,
  output logic [width-1:0]     load_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [$clog2(d)-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [width-1:0]     mem_wdata,
  input  logic [width-1:0]     mem_rdata,
  input  logic                 mem_ready
);

  localparam int unsigned AW = $clog2(d);
  localparam int unsigned WW = $clog2(max_wait + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t         state;
  logic [1:0]     off_q;
  logic [2:0]     f3_q;
  logic           is_store_q;
  logic [WW-1:0]  wait_cnt;

  logic             bad_c;
  logic [3:0]       be_c;
  logic [width-1:0] wd_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [width-1:0] ld_c;

  // Upstream hold: while an access is being accepted or is outstanding
  assign stall = ((state == IDLE) && req_valid && (is_load || is_store)) || (state == REQ);

  // Legality checks plus store byte enables and lane-replicated store data
  always_comb begin
    bad_c = 1'b0;
    be_c  = 4'b0000;
    wd_c  = '0;
    if (is_load && is_store) bad_c = 1'b1;
    case (funct3)
      3'b000: begin
        be_c = 4'b0001 << addr[1:0];
        wd_c = width'({4{wdata[7:0]}});
      end
      3'b001: begin
        be_c = addr[1] ? 4'b1100 : 4'b0011;
        wd_c = width'({2{wdata[15:0]}});
        if (addr[0]) bad_c = 1'b1;
      end
      3'b010: begin
        be_c = 4'b1111;
        wd_c = wdata;
        if (addr[1:0] != 2'b00) bad_c = 1'b1;
      end
      3'b100: begin
        if (is_store) bad_c = 1'b1;
      end
      3'b101: begin
        if (is_store || addr[0]) bad_c = 1'b1;
      end
      default: bad_c = 1'b1;
    endcase
    if (addr[width-1:2] >= (width-2)'(d)) bad_c = 1'b1;
  end

  // Lane select and extension of the returned memory word
  always_comb begin
    byte_c = mem_rdata[7:0];
    half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_c   = mem_rdata;
    case (off_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    case (f3_q)
      3'b000:  ld_c = {{(width-8){byte_c[7]}}, byte_c};
      3'b001:  ld_c = {{(width-16){half_c[15]}}, half_c};
      3'b100:  ld_c = width'(byte_c);
      3'b101:  ld_c = width'(half_c);
      default: ld_c = mem_rdata;
    endcase
  end

  // Access FSM with registered memory-side and writeback-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      off_q      <= '0;
      f3_q       <= '0;
      is_store_q <= 1'b0;
      wait_cnt   <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      load_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && (is_load || is_store)) begin
            off_q      <= addr[1:0];
            f3_q       <= funct3;
            is_store_q <= is_store;
            wait_cnt   <= '0;
            if (bad_c) begin
              state     <= DONE;
              done      <= 1'b1;
              fault     <= 1'b1;
              load_data <= '0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= addr[AW+1:2];
              mem_be    <= is_store ? be_c : 4'b0000;
              mem_wdata <= is_store ? wd_c : '0;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state     <= DONE;
            done      <= 1'b1;
            fault     <= 1'b0;
            load_data <= is_store_q ? '0 : ld_c;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else if (wait_cnt == WW'(max_wait - 1)) begin
            // Timed out: drop the request and report a fault
            state     <= DONE;
            done      <= 1'b1;
            fault     <= 1'b1;
            load_data <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          fault     <= 1'b0;
          load_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors push expected memory
// requests and completions; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .fault(fault), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic flt; logic [31:0] ld; int cyc; } resp_t;
  typedef struct { logic we; logic [6:0] ma; logic [3:0] be; logic [31:0] wd; int ncyc; } mreq_t;

  resp_t resp_q[$];
  mreq_t req_q[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int mem_delay = 0;
  logic [31:0] mem_rd = '0;
  logic ghost = 1'b0;
  int mcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Memory responder: asserts mem_ready after mem_delay request cycles (-1 = never)
  always @(negedge clk) begin
    if (mem_req) begin
      if (mcnt == mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = mem_rd;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_DEAD;
      end
      mcnt++;
    end else begin
      mem_ready = ghost;
      mem_rdata = 32'h5555_5555;
      mcnt = 0;
    end
  end

  // Monitor: checks each new memory request and each completion against the queues
  logic prev_req = 1'b0;
  int cur_n = 0;
  int cur_exp = 0;
  always @(negedge clk) begin
    resp_t r;
    mreq_t m;
    if (mem_req && !prev_req) begin
      cur_n = 0;
      cur_exp = 0;
      if (req_q.size() == 0) chk("unexpected_mem_req", 64'(mem_req), 64'd0);
      else begin
        m = req_q.pop_front();
        chk("mem_we", 64'(mem_we), 64'(m.we));
        chk("mem_addr", 64'(mem_addr), 64'(m.ma));
        chk("mem_be", 64'(mem_be), 64'(m.be));
        chk("mem_wdata", 64'(mem_wdata), 64'(m.wd));
        cur_exp = m.ncyc;
      end
    end
    if (mem_req) begin
      cur_n++;
      chk("stall_in_req", 64'(stall), 64'd1);
    end
    if (!mem_req && prev_req && cur_exp != 0) chk("req_cycles", 64'(cur_n), 64'(cur_exp));
    prev_req = mem_req;
    if (done) begin
      if (resp_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        r = resp_q.pop_front();
        chk("fault", 64'(fault), 64'(r.flt));
        chk("load_data", 64'(load_data), 64'(r.ld));
        chk("done_cycle", 64'(cyc), 64'(r.cyc));
        chk("stall_in_done", 64'(stall), 64'd0);
      end
    end
  end

  // Present one instruction, queue its expectations, hold it until stall drops
  task automatic issue(input logic l, input logic s, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd,
                       input logic flt, input logic [31:0] ld, input int lat,
                       input logic [6:0] ma, input logic [3:0] be,
                       input logic [31:0] mwd, input int ncyc);
    int n;
    @(negedge clk);
    mem_delay = dly;
    mem_rd = rd;
    req_valid = 1'b1;
    is_load = l;
    is_store = s;
    funct3 = f;
    addr = a;
    wdata = wd;
    if (ncyc > 0) req_q.push_back('{s, ma, be, mwd, ncyc});
    resp_q.push_back('{flt, ld, cyc + lat});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 100);
    chk("stall_release_bound", 64'(n < 100), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {60'd0, done, fault, mem_req, mem_we}, 64'd0);
    chk("reset_data", {load_data, mem_wdata}, 64'd0);
    chk("reset_misc", {52'd0, mem_addr, mem_be, stall}, 64'd0);
    reset = 1'b0;

    // Basic stores/loads, back-to-back
    issue(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        2, 7'd4,   4'hF, 32'hDEADBEEF, 1);
    issue(1, 0, 3'b000, 32'h13,  32'h0,        0, 32'h80FF0000, 0, 32'hFFFFFF80, 2, 7'd4,   4'h0, 32'h0,        1);
    issue(1, 0, 3'b100, 32'h13,  32'h0,        0, 32'h80FF0000, 0, 32'h00000080, 2, 7'd4,   4'h0, 32'h0,        1);
    issue(0, 1, 3'b001, 32'h22,  32'h00001234, 0, 32'h0,        0, 32'h0,        2, 7'd8,   4'hC, 32'h12341234, 1);
    issue(1, 0, 3'b101, 32'h22,  32'h0,        0, 32'hABCD0000, 0, 32'h0000ABCD, 2, 7'd8,   4'h0, 32'h0,        1);
    issue(0, 1, 3'b000, 32'h05,  32'h123456A5, 0, 32'h0,        0, 32'h0,        2, 7'd1,   4'h2, 32'hA5A5A5A5, 1);
    issue(1, 0, 3'b001, 32'h02,  32'h0,        0, 32'h80010000, 0, 32'hFFFF8001, 2, 7'd0,   4'h0, 32'h0,        1);
    issue(1, 0, 3'b010, 32'h1FC, 32'h0,        0, 32'h12345678, 0, 32'h12345678, 2, 7'd127, 4'h0, 32'h0,        1);

    // Faults detected at accept: no memory request, done one cycle later
    issue(1, 0, 3'b010, 32'h06,  32'h0, 0, 32'h0, 1, 32'h0, 1, 7'd0, 4'h0, 32'h0, 0);
    issue(1, 0, 3'b010, 32'h200, 32'h0, 0, 32'h0, 1, 32'h0, 1, 7'd0, 4'h0, 32'h0, 0);
    issue(1, 0, 3'b011, 32'h0,   32'h0, 0, 32'h0, 1, 32'h0, 1, 7'd0, 4'h0, 32'h0, 0);
    issue(0, 1, 3'b100, 32'h0,   32'h0, 0, 32'h0, 1, 32'h0, 1, 7'd0, 4'h0, 32'h0, 0);
    issue(1, 1, 3'b010, 32'h0,   32'h0, 0, 32'h0, 1, 32'h0, 1, 7'd0, 4'h0, 32'h0, 0);
    issue(1, 0, 3'b001, 32'h01,  32'h0, 0, 32'h0, 1, 32'h0, 1, 7'd0, 4'h0, 32'h0, 0);

    // Nothing to accept: no stall, no request, stray mem_ready ignored
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
    ghost = 1'b1;
    @(negedge clk);
    chk("idle_no_kind_stall", 64'(stall), 64'd0);
    @(negedge clk);
    chk("idle_no_kind_req", {62'd0, mem_req, done}, 64'd0);
    req_valid = 1'b0; is_load = 1'b1;
    @(negedge clk);
    chk("idle_no_valid_stall", 64'(stall), 64'd0);
    ghost = 1'b0;
    is_load = 1'b0;

    // Reset while a request is outstanding
    @(negedge clk);
    mem_delay = -1;
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0;
    req_q.push_back('{1'b0, 7'd0, 4'h0, 32'h0, 0});
    repeat (3) @(negedge clk);
    chk("pre_reset_req", 64'(mem_req), 64'd1);
    reset = 1'b1; req_valid = 1'b0; is_load = 1'b0;
    @(negedge clk);
    chk("reset_in_req", {61'd0, mem_req, stall, done}, 64'd0);
    reset = 1'b0;

    // Slow memory, then timeout (wait counter must start cleared after reset)
    issue(1, 0, 3'b010, 32'h40, 32'h0, 3,  32'hCAFEF00D, 0, 32'hCAFEF00D, 5,  7'd16, 4'h0, 32'h0, 4);
    issue(1, 0, 3'b010, 32'h44, 32'h0, -1, 32'h0,        1, 32'h0,        16, 7'd17, 4'h0, 32'h0, 15);
    issue(0, 1, 3'b010, 32'h48, 32'h01020304, 0, 32'h0,  0, 32'h0,        2,  7'd18, 4'hF, 32'h01020304, 1);

    @(negedge clk);
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
